if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage that produces the IF/ID stream (if_pc, if_pc_plus4, if_insn, if_en) consumed by decoder.
//  Drives a req/ack instruction-memory port and holds the IF/ID register under stall.
//  Applies branch redirects (br_taken from ID) and pipeline flushes (new_pc from ctrl).
//  A one-entry skid buffer keeps a fetched word that arrives while the stage is stalled.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INSN  32'h0000_0013  bubble word (addi x0,x0,0) driven when if_en=0
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high reset
//  stall         in   1   hold IF/ID register (ld_hazard / ctrl stall)
//  flush         in   1   discard IF/ID contents, redirect to new_pc
//  new_pc        in   32  flush target
//  br_taken      in   1   branch/jump resolved taken in ID
//  br_addr       in   32  branch target
//  imem_req      out  1   fetch request; addr held stable until imem_ack
//  imem_addr     out  32  fetch address, bits [1:0] always 0
//  imem_ack      in   1   read data valid this cycle (may arrive same cycle as req)
//  imem_rd_data  in   32  instruction word
//  if_pc         out  32  PC of if_insn
//  if_pc_plus4   out  32  if_pc + 4 (mod 2^32)
//  if_insn       out  32  instruction to decoder
//  if_en         out  1   IF/ID register valid
// BEHAVIOUR
//  Reset: if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_insn=NOP_INSN, if_en=0, imem_req=0,
//   fetch_pc=RESET_PC, skid empty, state=IDLE. Reset mid-transaction abandons it; acks in IDLE are ignored.
//  States: IDLE -> REQ (unconditional next cycle).
//   REQ: imem_req=1, imem_addr=fetch_pc. On ack, the word is accepted, fetch_pc+=4, stay REQ.
//   DISCARD: redirect arrived without ack; imem_req=1 holds old addr; on ack drop data,
//    fetch_pc=pending target, -> REQ.
//   HOLD: skid full; imem_req=0 until skid drains, then -> REQ.
//  Accepted word, stall=0, skid empty: next edge if_pc=addr, if_insn=data, if_en=1.
//  Accepted word with stall=1: word goes to skid (with its pc), -> HOLD. IF/ID holds all outputs while stall=1.
//  stall 1->0 with skid full: skid moves to IF/ID on the next edge, skid emptied.
//  REQ with no ack and stall=0: next edge if_en=0, if_insn=NOP_INSN (bubble); if_pc holds.
//  Redirect priority: reset > flush > br_taken > stall. Target = flush ? new_pc : br_addr, bits [1:0] forced 0.
//  On redirect: next edge if_en=0, if_insn=NOP_INSN, skid cleared.
//   If no request is outstanding or ack is present this cycle, fetch_pc=target and go to REQ (any acked data is dropped).
//   Otherwise latch target, -> DISCARD.
//   A redirect while in DISCARD overwrites the pending target.
//  Zero-wait memory (ack with req): throughput 1 insn/cycle; first if_en=1 at 2nd edge after reset deasserts.
//  Redirect penalty: >=1 bubble; no word is ever duplicated or lost.
//  fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000.
// TESTING
//  T1 reset 2 cycles, imem acks every req with data=addr^32'hA5A5_0000:
//   if_pc 0x0,0x4,0x8 on consecutive cycles; if_en=1 from 2nd edge; if_pc_plus4 = if_pc+4.
//  T2 ack delayed 3 cycles on addr 0x4: 3 cycles if_en=0/if_insn=0x13 with if_pc held,
//   then if_pc=0x4 exactly once, if_en=1.
//  T3 stall=1 for 2 cycles while 0x8 acked: outputs hold 0x4; imem_req=0 during HOLD;
//   after release if_pc=0x8 next edge, then 0xC; no loss or duplication.
//  T4 br_taken=1, br_addr=0x103 while 0x8 outstanding (ack 2 cycles later): 0x8 data dropped;
//   if_en=0 meanwhile; next valid if_pc=0x100.
//  T5 flush=1, new_pc=0x200 with br_taken=1, br_addr=0x100, stall=1 in same cycle:
//   skid cleared, if_en=0; next valid if_pc=0x200.
//  T6 reset asserted during DISCARD with late ack: outputs at reset values after edge;
//   stale ack ignored; first valid if_pc=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a req/ack instruction memory, feeds the IF/ID
// register and handles stalls, branch redirects, flushes and a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rd_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_insn,
    output logic        if_en
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] pend_pc, pend_pc_next;
    logic        skid_valid, skid_valid_next;
    logic [31:0] skid_pc, skid_pc_next;
    logic [31:0] skid_insn, skid_insn_next;
    logic [31:0] if_pc_next, if_insn_next;
    logic        if_en_next;
    logic        redirect;
    logic [31:0] target;

    assign redirect    = flush | br_taken;
    assign target      = (flush ? new_pc : br_addr) & 32'hFFFF_FFFC;
    assign imem_req    = (state == REQ) || (state == DISCARD);
    assign imem_addr   = fetch_pc;
    assign if_pc_plus4 = if_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC & 32'hFFFF_FFFC;
            pend_pc    <= RESET_PC & 32'hFFFF_FFFC;
            skid_valid <= 1'b0;
            skid_pc    <= RESET_PC;
            skid_insn  <= NOP_INSN;
            if_pc      <= RESET_PC;
            if_insn    <= NOP_INSN;
            if_en      <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            pend_pc    <= pend_pc_next;
            skid_valid <= skid_valid_next;
            skid_pc    <= skid_pc_next;
            skid_insn  <= skid_insn_next;
            if_pc      <= if_pc_next;
            if_insn    <= if_insn_next;
            if_en      <= if_en_next;
        end
    end

    // Redirects win over stall; a request still waiting for its ack must be
    // drained in DISCARD so the memory sees a stable address until it answers.
    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        pend_pc_next    = pend_pc;
        skid_valid_next = skid_valid;
        skid_pc_next    = skid_pc;
        skid_insn_next  = skid_insn;
        if_pc_next      = if_pc;
        if_insn_next    = if_insn;
        if_en_next      = if_en;

        if (redirect) begin
            if_en_next      = 1'b0;
            if_insn_next    = NOP_INSN;
            skid_valid_next = 1'b0;
            if (!imem_req || imem_ack) begin
                fetch_pc_next = target;
                state_next    = REQ;
            end else begin
                pend_pc_next = target;
                state_next   = DISCARD;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_next = REQ;
                    if (!stall) begin
                        if_en_next   = 1'b0;
                        if_insn_next = NOP_INSN;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (stall) begin
                            skid_valid_next = 1'b1;
                            skid_pc_next    = fetch_pc;
                            skid_insn_next  = imem_rd_data;
                            state_next      = HOLD;
                        end else begin
                            if_pc_next   = fetch_pc;
                            if_insn_next = imem_rd_data;
                            if_en_next   = 1'b1;
                        end
                    end else if (!stall) begin
                        if_en_next   = 1'b0;
                        if_insn_next = NOP_INSN;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        fetch_pc_next = pend_pc;
                        state_next    = REQ;
                    end
                    if (!stall) begin
                        if_en_next   = 1'b0;
                        if_insn_next = NOP_INSN;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_pc_next      = skid_pc;
                        if_insn_next    = skid_insn;
                        if_en_next      = skid_valid;
                        skid_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a simple memory model answers requests with
// addr ^ 0xA5A5_0000, and each step checks hand-computed IF/ID and port values.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [31:0] new_pc, br_addr;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rd_data;
    logic [31:0] if_pc, if_pc_plus4, if_insn;
    logic        if_en;
    logic        ack_en, force_ack;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    always #5 clk = ~clk;

    // force_ack lets the bench present an ack with no request pending
    assign imem_ack     = ack_en & (imem_req | force_ack);
    assign imem_rd_data = imem_addr ^ KEY;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rd_data(imem_rd_data),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_insn(if_insn), .if_en(if_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic en,
                              input logic [31:0] pc, input logic [31:0] insn);
        check({tag, ".en"}, {31'd0, if_en}, {31'd0, en});
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
        check({tag, ".insn"}, if_insn, insn);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0; ack_en = 1'b1; force_ack = 1'b0;
        #1;
        cycle(); cycle();
        check_ifid("reset", 1'b0, 32'h0, NOP);
        check("reset.req", {31'd0, imem_req}, 32'd0);

        // zero-wait streaming
        reset = 1'b0;
        cycle();
        check_ifid("idle", 1'b0, 32'h0, NOP);
        check("idle.req", {31'd0, imem_req}, 32'd1);
        check("idle.addr", imem_addr, 32'h0);
        cycle(); check_ifid("s0", 1'b1, 32'h0, 32'hA5A5_0000);
        cycle(); check_ifid("s4", 1'b1, 32'h4, 32'hA5A5_0004);

        // delayed ack on 0x8
        ack_en = 1'b0;
        cycle(); check_ifid("w1", 1'b0, 32'h4, NOP);
        check("w1.addr", imem_addr, 32'h8);
        cycle(); check_ifid("w2", 1'b0, 32'h4, NOP);
        cycle(); check_ifid("w3", 1'b0, 32'h4, NOP);
        ack_en = 1'b1;
        cycle(); check_ifid("w8", 1'b1, 32'h8, 32'hA5A5_0008);

        // stall while 0xC is acked: goes to skid, request drops
        stall = 1'b1;
        cycle(); check_ifid("st1", 1'b1, 32'h8, 32'hA5A5_0008);
        check("st1.req", {31'd0, imem_req}, 32'd0);
        cycle(); check_ifid("st2", 1'b1, 32'h8, 32'hA5A5_0008);
        check("st2.req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        cycle(); check_ifid("stC", 1'b1, 32'hC, 32'hA5A5_000C);
        check("stC.addr", imem_addr, 32'h10);
        cycle(); check_ifid("st10", 1'b1, 32'h10, 32'hA5A5_0010);

        // branch while 0x14 outstanding, ack two cycles later
        ack_en = 1'b0; br_taken = 1'b1; br_addr = 32'h103;
        cycle(); check_ifid("br1", 1'b0, 32'h10, NOP);
        check("br1.req", {31'd0, imem_req}, 32'd1);
        check("br1.addr", imem_addr, 32'h14);
        br_taken = 1'b0;
        cycle(); check_ifid("br2", 1'b0, 32'h10, NOP);
        check("br2.addr", imem_addr, 32'h14);
        ack_en = 1'b1;
        cycle(); check_ifid("br3", 1'b0, 32'h10, NOP);
        check("br3.addr", imem_addr, 32'h100);
        cycle(); check_ifid("br100", 1'b1, 32'h100, 32'hA5A5_0100);

        // fill skid with 0x104, then flush+branch+stall together
        stall = 1'b1;
        cycle(); check_ifid("fl0", 1'b1, 32'h100, 32'hA5A5_0100);
        flush = 1'b1; new_pc = 32'h200; br_taken = 1'b1; br_addr = 32'h100;
        cycle(); check_ifid("fl1", 1'b0, 32'h100, NOP);
        check("fl1.addr", imem_addr, 32'h200);
        flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
        cycle(); check_ifid("fl200", 1'b1, 32'h200, 32'hA5A5_0200);

        // address wrap through 0xFFFF_FFFC
        flush = 1'b1; new_pc = 32'hFFFF_FFFE;
        cycle(); check_ifid("wr0", 1'b0, 32'h200, NOP);
        check("wr0.addr", imem_addr, 32'hFFFF_FFFC);
        flush = 1'b0;
        cycle(); check_ifid("wrTop", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        cycle(); check_ifid("wr00", 1'b1, 32'h0, 32'hA5A5_0000);

        // reset during DISCARD with a late ack
        ack_en = 1'b0; br_taken = 1'b1; br_addr = 32'h300;
        cycle(); check_ifid("rd1", 1'b0, 32'h0, NOP);
        br_taken = 1'b0; reset = 1'b1; ack_en = 1'b1;
        cycle(); check_ifid("rd2", 1'b0, 32'h0, NOP);
        check("rd2.req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; force_ack = 1'b1;
        cycle(); check_ifid("rd3", 1'b0, 32'h0, NOP);
        check("rd3.addr", imem_addr, 32'h0);
        force_ack = 1'b0;
        cycle(); check_ifid("rd0", 1'b1, 32'h0, 32'hA5A5_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
